inverse_substitution_table_builder: RTL
=======================================

// Module: inverse_substitution_table_builder
// PURPOSE
// - Builds the inverse of the 256-entry byte substitution table from its 16 x 128-bit rows
//   (inv[S[i]] = i), so the decryption datapath gets matching inverse rows.
// - Sits between the S-box row source and the decryption Feistel top.
// - Sequential: walks the forward table BYTES_PER_CYCLE entries per clock.
// - Flags non-bijective tables.
// PARAMETERS
// - BYTES_PER_CYCLE   1   forward entries processed per clock; legal values 1,2,4,8,16
// PORTS
// - clk                          in   1    clock, rising edge
// - rstn                         in   1    asynchronous active-low reset
// - substitution_box_row0..15    in   128  forward table rows; must be stable while substitution_table_valid=1
// - substitution_table_valid     in   1    forward table present and stable
// - inverse_box_row0..15         out  128  inverse table rows, same packing as input
// - inverse_table_valid          out  1    inverse rows complete and correct
// - table_error                  out  1    forward table not a permutation
// - busy                         out  1    build in progress
// BEHAVIOUR
// - Packing (both directions): entry k = 16*r+c is row_r[127-8*c -: 8].
//   Example: S[0x00] = row0[127:120].
// - Reset (rstn=0, async): state=IDLE; all inverse rows=0; inverse_table_valid=0; table_error=0;
//   busy=0; seen[255:0]=0; idx=0.
// - States: IDLE, BUILD, DONE, ERROR.
// - IDLE:
//   - substitution_table_valid=1 at an edge -> BUILD.
//   - That edge clears the inverse rows and seen, sets idx=0 and busy=1. No entry is processed.
// - BUILD, each edge:
//   - For j=0..BPC-1: v=S[idx+j]; write inv byte v := idx+j; set seen[v].
//   - idx += BPC, 8-bit; wrap to 0 marks completion.
//   - Collision: if seen[v] was already set, or two v in the same group are equal -> ERROR.
//     The same edge sets table_error=1 and busy=0; partial inverse writes are don't-care.
//   - If the group holding idx=256-BPC completes with no collision -> DONE.
//     The same edge sets inverse_table_valid=1 and busy=0.
//   - Latency: inverse_table_valid rises 256/BPC edges after the IDLE->BUILD edge
//     (256 edges for BPC=1, 16 for BPC=16).
//   - substitution_table_valid=0 at any BUILD edge:
//     - abort, no processing; -> IDLE; busy=0.
//     - inverse_table_valid and table_error stay 0.
// - DONE:
//   - Hold rows, with inverse_table_valid=1, while substitution_table_valid=1.
//   - substitution_table_valid=0 -> IDLE; inverse_table_valid=0; rows hold their value.
// - ERROR:
//   - table_error=1 and inverse_table_valid=0 held while substitution_table_valid=1.
//   - substitution_table_valid=0 -> IDLE; table_error=0.
// - Re-build: only via a 0->1 sequence on substitution_table_valid. Row changes while valid stays
//   high are not detected (caller contract).
// - Simultaneous: the abort check (valid=0) has priority over completion and over collision in
//   the same edge.
// - Reset mid-BUILD returns to the IDLE reset values immediately, regardless of clock.
// TESTING
// - Forward AES S-box (row0 = 63 7c 77 7b ...), BPC=1, valid held high:
//   - inverse_table_valid=1 exactly 256 edges after the start edge; busy=0.
//   - inverse_box_row0 = 52096ad53036a538bf40a39e81f3d7fb.
// - Identity table (S[i]=i), BPC=4: valid after 64 edges; every inverse row equals its input row.
// - AES S-box with S[0x01] forced to 0x63 (duplicate), BPC=1:
//   - table_error=1 on the edge that processes idx=1 (2nd BUILD edge).
//   - inverse_table_valid stays 0.
// - Drop substitution_table_valid after 100 BUILD edges:
//   - next edge -> IDLE, busy=0, no valid/error.
//   - Re-raise valid -> full 256-edge build succeeds.
// - Assert rstn=0 between clock edges mid-BUILD:
//   - outputs go to 0 immediately.
//   - After release with valid high, a fresh build completes normally.
// - DONE then valid=0 then valid=1 with the identity table:
//   - inverse_table_valid drops for at least 1 cycle.
//   - New rows equal the identity table after 256/BPC edges.

Source files
------------

// File: rtl/inverse_substitution_table_builder.sv
// Builds the inverse of a 256-entry byte substitution table, BYTES_PER_CYCLE entries per clock,
// and flags forward tables that are not permutations.
module inverse_substitution_table_builder #(
   parameter int BYTES_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [127:0] substitution_box_row0,
   input  logic [127:0] substitution_box_row1,
   input  logic [127:0] substitution_box_row2,
   input  logic [127:0] substitution_box_row3,
   input  logic [127:0] substitution_box_row4,
   input  logic [127:0] substitution_box_row5,
   input  logic [127:0] substitution_box_row6,
   input  logic [127:0] substitution_box_row7,
   input  logic [127:0] substitution_box_row8,
   input  logic [127:0] substitution_box_row9,
   input  logic [127:0] substitution_box_row10,
   input  logic [127:0] substitution_box_row11,
   input  logic [127:0] substitution_box_row12,
   input  logic [127:0] substitution_box_row13,
   input  logic [127:0] substitution_box_row14,
   input  logic [127:0] substitution_box_row15,
   input  logic         substitution_table_valid,
   output logic [127:0] inverse_box_row0,
   output logic [127:0] inverse_box_row1,
   output logic [127:0] inverse_box_row2,
   output logic [127:0] inverse_box_row3,
   output logic [127:0] inverse_box_row4,
   output logic [127:0] inverse_box_row5,
   output logic [127:0] inverse_box_row6,
   output logic [127:0] inverse_box_row7,
   output logic [127:0] inverse_box_row8,
   output logic [127:0] inverse_box_row9,
   output logic [127:0] inverse_box_row10,
   output logic [127:0] inverse_box_row11,
   output logic [127:0] inverse_box_row12,
   output logic [127:0] inverse_box_row13,
   output logic [127:0] inverse_box_row14,
   output logic [127:0] inverse_box_row15,
   output logic         inverse_table_valid,
   output logic         table_error,
   output logic         busy,
   output logic [1:0]   state_dbg
);

   // Handshake: substitution_table_valid is a level, not a pulse. While it is high the rows
   // must not change; dropping it aborts a build or releases a finished/failed result, and a
   // new build needs it to go low and come back high.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   localparam logic [7:0] IDX_STEP = 8'(BYTES_PER_CYCLE);
   localparam logic [7:0] IDX_LAST = 8'(256 - BYTES_PER_CYCLE);

   state_t              state_q;
   state_t              state_d;
   logic [15:0][127:0]  fwd_rows;
   logic [15:0][127:0]  inv_rows;
   logic [7:0]          fwd_bytes [256];
   logic [255:0][7:0]   inv_q;
   logic [255:0]        seen_q;
   logic [7:0]          idx_q;
   logic [7:0]          grp_k [BYTES_PER_CYCLE];
   logic [7:0]          grp_v [BYTES_PER_CYCLE];
   logic                collision;
   logic                last_group;

   assign fwd_rows[0]  = substitution_box_row0;
   assign fwd_rows[1]  = substitution_box_row1;
   assign fwd_rows[2]  = substitution_box_row2;
   assign fwd_rows[3]  = substitution_box_row3;
   assign fwd_rows[4]  = substitution_box_row4;
   assign fwd_rows[5]  = substitution_box_row5;
   assign fwd_rows[6]  = substitution_box_row6;
   assign fwd_rows[7]  = substitution_box_row7;
   assign fwd_rows[8]  = substitution_box_row8;
   assign fwd_rows[9]  = substitution_box_row9;
   assign fwd_rows[10] = substitution_box_row10;
   assign fwd_rows[11] = substitution_box_row11;
   assign fwd_rows[12] = substitution_box_row12;
   assign fwd_rows[13] = substitution_box_row13;
   assign fwd_rows[14] = substitution_box_row14;
   assign fwd_rows[15] = substitution_box_row15;

   // Entry k = 16*r + c lives in row r, most significant byte first.
   for (genvar r = 0; r < 16; r++) begin : g_row
      for (genvar c = 0; c < 16; c++) begin : g_col
         assign fwd_bytes[16*r+c]          = fwd_rows[r][127-8*c -: 8];
         assign inv_rows[r][127-8*c -: 8] = inv_q[16*r+c];
      end
   end

   assign inverse_box_row0  = inv_rows[0];
   assign inverse_box_row1  = inv_rows[1];
   assign inverse_box_row2  = inv_rows[2];
   assign inverse_box_row3  = inv_rows[3];
   assign inverse_box_row4  = inv_rows[4];
   assign inverse_box_row5  = inv_rows[5];
   assign inverse_box_row6  = inv_rows[6];
   assign inverse_box_row7  = inv_rows[7];
   assign inverse_box_row8  = inv_rows[8];
   assign inverse_box_row9  = inv_rows[9];
   assign inverse_box_row10 = inv_rows[10];
   assign inverse_box_row11 = inv_rows[11];
   assign inverse_box_row12 = inv_rows[12];
   assign inverse_box_row13 = inv_rows[13];
   assign inverse_box_row14 = inv_rows[14];
   assign inverse_box_row15 = inv_rows[15];

   always_comb begin
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         grp_k[j] = idx_q + 8'(j);
         grp_v[j] = fwd_bytes[grp_k[j]];
      end
   end

   // A value repeats if it was written by an earlier group or twice within this group.
   always_comb begin
      collision = 1'b0;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         if (seen_q[grp_v[j]]) collision = 1'b1;
         for (int m = 0; m < j; m++) begin
            if (grp_v[m] == grp_v[j]) collision = 1'b1;
         end
      end
   end

   assign last_group = (idx_q == IDX_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Abort (valid low) outranks both collision and completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (substitution_table_valid) state_d = BUILD;
         BUILD: begin
            if (!substitution_table_valid) state_d = IDLE;
            else if (collision)            state_d = ERROR;
            else if (last_group)           state_d = DONE;
         end
         DONE:  if (!substitution_table_valid) state_d = IDLE;
         ERROR: if (!substitution_table_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inv_q  <= '0;
         seen_q <= '0;
         idx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (substitution_table_valid) begin
                  inv_q  <= '0;
                  seen_q <= '0;
                  idx_q  <= '0;
               end
            end
            BUILD: begin
               if (substitution_table_valid) begin
                  for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                     inv_q[grp_v[j]]  <= grp_k[j];
                     seen_q[grp_v[j]] <= 1'b1;
                  end
                  idx_q <= idx_q + IDX_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy                = (state_q == BUILD);
   assign inverse_table_valid = (state_q == DONE);
   assign table_error         = (state_q == ERROR);
   assign state_dbg           = state_q;

endmodule
